serial_add_arbiter: RTL and testbench
=====================================

# serial_add_arbiter

Shares one bit-serial adder slice between two requesters. The slice is a full adder built from two half adders. Round-robin arbitration picks a requester, captures its WIDTH-bit operands, and adds them LSB-first over WIDTH cycles. It then presents sum, carry-out and owner with a one-cycle done pulse. It sits between the adder datapath and the client blocks, replacing per-client parallel adders.

## Interface
- WIDTH, 4, operand/sum width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- req0  input  1  requester 0 request; hold with a0/b0 stable until gnt0
- a0, b0  input  WIDTH  requester 0 operands
- req1  input  1  requester 1 request; hold with a1/b1 stable until gnt1
- a1, b1  input  WIDTH  requester 1 operands
- gnt0, gnt1  output  1  one-cycle pulse: operands of that requester captured
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: sum/cout/owner updated
- sum  output  WIDTH  result of last completed operation
- cout  output  1  carry-out of last completed operation
- owner  output  1  requester index of last completed operation

## Operation
- States: IDLE, RUN, DONE. Internal regs: opa, opb, acc (WIDTH), carry, cnt (ceil log2 WIDTH, min 1 bit), last (last granted index).
- All outputs are registered.
- Reset values: state=IDLE; gnt0=gnt1=busy=done=0; sum=0; cout=0; owner=0; last=1, so req0 wins the first tie. Internal regs are 0.
- IDLE, no req: stay; all pulses 0.
- IDLE, any req: grant by round-robin.
  - Single requester: grant it.
  - Both requesting: grant the index ≠ last.
  - On grant: load opa/opb from the granted port, carry=0, cnt=0, acc=0, last=granted, pulse gnt for that port, go to RUN.
- RUN, each cycle:
  - s = opa[0]^opb[0]^carry
  - carry = majority(opa[0], opb[0], carry)
  - opa, opb shift right by 1
  - acc = {s, acc[WIDTH-1:1]}
  - cnt++
- RUN exit: on the cycle when cnt==WIDTH-1, go to DONE. In the same edge, sum receives the final acc value (including this bit), cout the final carry, owner=last, and done=1.
- DONE: done returns to 0 and the state goes to IDLE. Requests are not sampled in DONE or RUN.
- sum/cout/owner hold their values until the next done; partial results never appear on sum.
- Arithmetic is modulo 2^WIDTH; {cout,sum} = a+b exactly.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Grant edge E0: gnt pulses and busy rises.
- Bits are processed on edges E1..E_WIDTH; done and results appear at edge E_WIDTH.
- At E_WIDTH+1, done falls and busy falls (IDLE).
- The earliest next grant is at E_WIDTH+2, giving one operation per WIDTH+2 cycles.
- Requester protocol:
  - A requester may drop req before gnt without side effect.
  - A requester holding req after gnt is treated as a new request at the next IDLE.
- Reset mid-operation: all state clears immediately (async). The in-flight operation is lost, no done is issued, and sum/cout/owner return to 0.
- Simultaneous req0/req1 arriving while busy: arbitration happens at the next IDLE cycle using last.

## Test plan
- Reset, then only req0 with a0=7, b0=9 (WIDTH=4) -> gnt0 at E0; done at E4 with sum=0, cout=1, owner=0; busy low after E5.
- Only req1 with a1=15, b1=15 -> sum=14, cout=1, owner=1. Then a1=0, b1=0 -> sum=0, cout=0.
- req0 and req1 both held continuously after reset, with a0=1,b0=2 and a1=3,b1=4 -> grants alternate 0,1,0,1 every 6 cycles; results alternate sum=3/owner=0 and sum=7/owner=1.
- rst_n low for one cycle at E2 of an operation -> done never pulses; all outputs read 0; the next request completes normally.
- Exhaustive sweep: all 256 a0/b0 pairs through requester 0 -> every {cout,sum} equals a0+b0, and each operation takes exactly 6 cycles from grant to grant.
- Build with WIDTH=1 and apply the four operand pairs (0,0), (0,1), (1,0), (1,1) -> {cout,sum} = 00, 01, 01, 10; done arrives 1 cycle after gnt.

Source files
------------

// File: rtl/serial_add_arbiter_if.sv
// Client-side bundle for the shared bit-serial adder: two request ports in,
// grant/result signals out.
//
// Handshake: a requester raises reqN with aN/bN stable and keeps both steady
// until gntN pulses for one cycle; that pulse marks the cycle its operands were
// captured. A req still high after gntN counts as a fresh request at the next
// IDLE. done pulses once when sum/cout/owner have been refreshed.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             owner;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, sum, cout, owner
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, sum, cout, owner
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// One full-adder slice (two half adders) time-shared between two clients via
// round-robin; operands are added LSB-first over WIDTH cycles.
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_arbiter_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] opa, opa_d;
  logic [WIDTH-1:0] opb, opb_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic             carry, carry_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             last, last_d;

  logic             gnt0_d, gnt1_d, busy_d, done_d, cout_d, owner_d;
  logic [WIDTH-1:0] sum_d;

  logic             grant_any;
  logic             grant_idx;

  // last==1 means requester 0 wins a tie, and vice versa.
  assign grant_any = bus.req0 | bus.req1;
  assign grant_idx = bus.req1 & (~bus.req0 | ~last);

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, bit_c;

  assign ha0_s = opa[0] ^ opb[0];
  assign ha0_c = opa[0] & opb[0];
  assign ha1_s = ha0_s ^ carry;
  assign ha1_c = ha0_s & carry;
  assign bit_s = ha1_s;
  assign bit_c = ha0_c | ha1_c;

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at acc[0].
  logic [WIDTH-1:0] acc_shift;
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift = bit_s;
    end else begin : g_acc_wn
      assign acc_shift = {bit_s, acc[WIDTH-1:1]};
    end
  endgenerate

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_any) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    opa_d   = opa;
    opb_d   = opb;
    acc_d   = acc;
    carry_d = carry;
    cnt_d   = cnt;
    last_d  = last;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = bus.sum;
    cout_d  = bus.cout;
    owner_d = bus.owner;
    busy_d  = (state_next != IDLE);
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          opa_d   = grant_idx ? bus.a1 : bus.a0;
          opb_d   = grant_idx ? bus.b1 : bus.b0;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          last_d  = grant_idx;
          gnt0_d  = ~grant_idx;
          gnt1_d  = grant_idx;
        end
      end
      RUN: begin
        opa_d   = opa >> 1;
        opb_d   = opb >> 1;
        carry_d = bit_c;
        acc_d   = acc_shift;
        cnt_d   = cnt + CW'(1);
        // Results publish only on the final bit so sum never shows a partial.
        if (cnt == CNT_LAST) begin
          sum_d   = acc_shift;
          cout_d  = bit_c;
          owner_d = last;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      last      <= 1'b1;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sum   <= '0;
      bus.cout  <= 1'b0;
      bus.owner <= 1'b0;
    end else begin
      opa       <= opa_d;
      opb       <= opb_d;
      acc       <= acc_d;
      carry     <= carry_d;
      cnt       <= cnt_d;
      last      <= last_d;
      bus.gnt0  <= gnt0_d;
      bus.gnt1  <= gnt1_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
      bus.sum   <= sum_d;
      bus.cout  <= cout_d;
      bus.owner <= owner_d;
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: WIDTH=4 instance for arbitration,
// timing and sweep scenarios, plus a WIDTH=1 instance for the single-bit case.
module tb_serial_add_arbiter;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] st;
  logic [1:0] st1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();
  serial_add_arbiter_if #(.WIDTH(1)) bus1 ();

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (st)
  );

  serial_add_arbiter #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .state_dbg (st1)
  );

  task automatic apply_reset();
    rst_n     = 1'b0;
    bus.req0  = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1  = 1'b0; bus.a1 = '0; bus.b1 = '0;
    bus1.req0 = 1'b0; bus1.a0 = '0; bus1.b0 = '0;
    bus1.req1 = 1'b0; bus1.a1 = '0; bus1.b1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request on the WIDTH=4 instance; latencies are in cycles
  // (-1 when the bound expires).
  task automatic do_req(input int which, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int gnt_lat, output int done_lat,
                        output logic [W-1:0] s, output logic c, output logic o,
                        output logic busy_g, output logic early);
    logic [W-1:0] sum_before;
    gnt_lat = -1; done_lat = -1; s = '0; c = 1'b0; o = 1'b0; busy_g = 1'b0; early = 1'b0;
    sum_before = bus.sum;
    if (which == 0) begin
      bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.gnt0) || (which == 1 && bus.gnt1)) begin
        gnt_lat = i;
        busy_g  = bus.busy;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (gnt_lat < 0) return;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        done_lat = i; s = bus.sum; c = bus.cout; o = bus.owner;
        break;
      end
      if (bus.sum !== sum_before) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    obs = {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.sum, bus.cout, bus.owner};
    n_cmp++;
    if (obs !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 10'd0);
    end
    n_cmp++;
    if (st !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", st);
    end
    n_cmp++;
    if ({bus1.done, bus1.sum, bus1.cout, bus1.busy} !== 4'd0) begin
      n_fail++; $display("FAIL reset_w1: got %b expected 0000", {bus1.done, bus1.sum, bus1.cout, bus1.busy});
    end
  endtask

  task automatic test_single_req0();
    int gl, dl; logic [W-1:0] s; logic c, o, bg, early;
    do_req(0, 4'd7, 4'd9, gl, dl, s, c, o, bg, early);
    n_cmp++; if (gl !== 1) begin n_fail++; $display("FAIL r0_gnt_lat: got %0d expected 1", gl); end
    n_cmp++; if (bg !== 1'b1) begin n_fail++; $display("FAIL r0_busy_at_gnt: got %b expected 1", bg); end
    n_cmp++; if (dl !== W) begin n_fail++; $display("FAIL r0_done_lat: got %0d expected %0d", dl, W); end
    n_cmp++; if (s !== 4'd0) begin n_fail++; $display("FAIL r0_sum: got %0d expected 0", s); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL r0_cout: got %b expected 1", c); end
    n_cmp++; if (o !== 1'b0) begin n_fail++; $display("FAIL r0_owner: got %b expected 0", o); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL r0_partial_sum: got %b expected 0", early); end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL r0_after_done: busy/done got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_req1();
    int gl, dl; logic [W-1:0] s; logic c, o, bg, early;
    do_req(1, 4'd15, 4'd15, gl, dl, s, c, o, bg, early);
    n_cmp++; if (gl !== 1) begin n_fail++; $display("FAIL r1a_gnt_lat: got %0d expected 1", gl); end
    n_cmp++; if (dl !== W) begin n_fail++; $display("FAIL r1a_done_lat: got %0d expected %0d", dl, W); end
    n_cmp++; if ({c, s} !== 5'd30) begin n_fail++; $display("FAIL r1a_result: got %0d expected 30", {c, s}); end
    n_cmp++; if (o !== 1'b1) begin n_fail++; $display("FAIL r1a_owner: got %b expected 1", o); end
    @(negedge clk);
    do_req(1, 4'd0, 4'd0, gl, dl, s, c, o, bg, early);
    n_cmp++; if ({c, s} !== 5'd0) begin n_fail++; $display("FAIL r1b_result: got %0d expected 0", {c, s}); end
    n_cmp++; if (o !== 1'b1) begin n_fail++; $display("FAIL r1b_owner: got %b expected 1", o); end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    int g_idx[8]; int g_cyc[8]; int d_sum[8]; int d_own[8];
    int ng, nd;
    ng = 0; nd = 0;
    apply_reset();
    bus.a0 = 4'd1; bus.b0 = 4'd2; bus.a1 = 4'd3; bus.b1 = 4'd4;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if ((bus.gnt0 || bus.gnt1) && ng < 8) begin
        g_idx[ng] = int'(bus.gnt1); g_cyc[ng] = cyc; ng++;
      end
      if (bus.done && nd < 8) begin
        d_sum[nd] = int'(bus.sum); d_own[nd] = int'(bus.owner); nd++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n_cmp++; if (ng !== 4) begin n_fail++; $display("FAIL alt_grant_count: got %0d expected 4", ng); end
    n_cmp++; if (nd !== 4) begin n_fail++; $display("FAIL alt_done_count: got %0d expected 4", nd); end
    for (int k = 0; k < 4; k++) begin
      if (k < ng) begin
        n_cmp++;
        if (g_idx[k] !== k % 2 || g_cyc[k] !== 1 + 6 * k) begin
          n_fail++;
          $display("FAIL alt_grant%0d: got idx %0d cyc %0d expected idx %0d cyc %0d",
                   k, g_idx[k], g_cyc[k], k % 2, 1 + 6 * k);
        end
      end
      if (k < nd) begin
        n_cmp++;
        if (d_sum[k] !== ((k % 2) ? 7 : 3) || d_own[k] !== k % 2) begin
          n_fail++;
          $display("FAIL alt_result%0d: got sum %0d owner %0d expected sum %0d owner %0d",
                   k, d_sum[k], d_own[k], (k % 2) ? 7 : 3, k % 2);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int gl, dl; logic [W-1:0] s; logic c, o, bg, early;
    logic saw_done;
    logic [9:0] obs;
    do_req(0, 4'd15, 4'd15, gl, dl, s, c, o, bg, early);
    @(negedge clk);
    bus.a0 = 4'd5; bus.b0 = 4'd6; bus.req0 = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b expected 1", bus.gnt0); end
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.sum, bus.cout, bus.owner};
    n_cmp++;
    if (obs !== 10'd0) begin n_fail++; $display("FAIL rm_outputs_cleared: got %b expected %b", obs, 10'd0); end
    n_cmp++; if (st !== 2'd0) begin n_fail++; $display("FAIL rm_state_cleared: got %0d expected 0", st); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b expected 0", saw_done); end
    do_req(0, 4'd2, 4'd3, gl, dl, s, c, o, bg, early);
    n_cmp++;
    if (gl !== 1 || dl !== W || {c, s} !== 5'd5 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_next_op: got gl %0d dl %0d res %0d owner %b expected gl 1 dl %0d res 5 owner 0",
               gl, dl, {c, s}, o, W);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int k, n_done, prev_g;
    k = 0; n_done = 0; prev_g = 0;
    bus.a0 = '0; bus.b0 = '0; bus.req0 = 1'b1;
    for (int cyc = 1; cyc <= 256 * 6 + 40; cyc++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        exp_q.push_back({1'b0, bus.a0} + {1'b0, bus.b0});
        if (k > 0) begin
          n_cmp++;
          if (cyc - prev_g !== 6) begin
            n_fail++; $display("FAIL sweep_period%0d: got %0d expected 6", k, cyc - prev_g);
          end
        end
        prev_g = cyc;
        k++;
        if (k < 256) begin
          bus.a0 = W'(k >> 4); bus.b0 = W'(k);
        end else begin
          bus.req0 = 1'b0;
        end
      end
      if (bus.done) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++;
        if ({bus.cout, bus.sum} !== exp_v || bus.owner !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_result%0d: got %0d owner %b expected %0d owner 0",
                   n_done, {bus.cout, bus.sum}, bus.owner, exp_v);
        end
        n_done++;
        if (n_done == 256) break;
      end
    end
    bus.req0 = 1'b0;
    n_cmp++; if (k !== 256) begin n_fail++; $display("FAIL sweep_grants: got %0d expected 256", k); end
    n_cmp++; if (n_done !== 256) begin n_fail++; $display("FAIL sweep_dones: got %0d expected 256", n_done); end
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [1:0] exp_r[4];
    logic [1:0] got;
    int gl, dl;
    exp_r[0] = 2'b00; exp_r[1] = 2'b01; exp_r[2] = 2'b01; exp_r[3] = 2'b10;
    for (int p = 0; p < 4; p++) begin
      gl = -1; dl = -1; got = 2'b11;
      bus1.a0 = p[1]; bus1.b0 = p[0]; bus1.req0 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (bus1.gnt0) begin gl = i; break; end
      end
      bus1.req0 = 1'b0;
      if (gl > 0) begin
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          if (bus1.done) begin dl = i; got = {bus1.cout, bus1.sum}; break; end
        end
      end
      n_cmp++;
      if (gl !== 1 || dl !== 1) begin
        n_fail++; $display("FAIL w1_latency%0d: got gnt %0d done %0d expected gnt 1 done 1", p, gl, dl);
      end
      n_cmp++;
      if (got !== exp_r[p]) begin
        n_fail++; $display("FAIL w1_result%0d: got %b expected %b", p, got, exp_r[p]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_req0();
    test_req1();
    test_alternate();
    test_reset_mid();
    test_sweep();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
